// File: rtl/de0_cv_irq_pkg.sv
// Shared constants for the DE0-CV interrupt controller slave: bus widths,
// register addresses and ACTIVE word layout.
package de0_cv_irq_pkg;

  localparam int DATA_W           = 16;
  localparam int ADDR_W           = 3;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd4;

endpackage

// File: rtl/de0_cv_irq_capture.sv
// Per-source capture: optional 2-flop synchronizer (IRQ_CTRL_SYNC_EN), delay
// flop, and edge/level pending selection with write-one-to-clear.
module de0_cv_irq_capture (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_i,
  input  logic edge_sel_i,
  input  logic w1c_i,
  output logic src_o,
  output logic pending_o
);

  logic src_s;
  logic src_dly_q;
  logic latch_q;
  logic latch_d;
  logic rise_s;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for sources outside this clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], irq_i};
    end
  end

  assign src_s = sync_q[1];
`else
  assign src_s = irq_i;
`endif

  assign rise_s = src_s & ~src_dly_q;

  // Latch is held clear in level mode so switching to edge mode never shows a stale capture
  always_comb begin
    latch_d = 1'b0;
    if (edge_sel_i) begin
      if (rise_s) begin
        latch_d = 1'b1;
      end else if (w1c_i) begin
        latch_d = 1'b0;
      end else begin
        latch_d = latch_q;
      end
    end else begin
      latch_d = 1'b0;
    end
  end

  // Delay flop and edge latch state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_dly_q <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      src_dly_q <= src_s;
      latch_q   <= latch_d;
    end
  end

  assign src_o     = src_s;
  assign pending_o = edge_sel_i ? latch_q : src_s;

endmodule

// File: rtl/de0_cv_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source capture, output-side masking,
// lowest-index priority encode and registered irq. Optional IRQ_CTRL_SYNC_EN.
module de0_cv_irq_ctrl
  import de0_cv_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] mask_d;
  logic [NUM_IRQ-1:0] edge_sel_q;
  logic [NUM_IRQ-1:0] edge_sel_d;
  logic [NUM_IRQ-1:0] pending_s;
  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] hit_s;
  logic [NUM_IRQ-1:0] w1c_s;
  logic [ID_W-1:0]    active_id_s;
  logic               active_valid_s;
  logic [DATA_W-1:0]  active_word_s;
  logic [DATA_W-1:0]  readdata_q;
  logic [DATA_W-1:0]  readdata_d;
  logic               irq_out_q;
  logic               irq_out_d;
  logic               wr_en_s;
  logic               wr_pending_s;
  logic               wr_mask_s;
  logic               wr_edge_s;
  logic               unused_wdata_s;

  assign wr_en_s      = chipselect & ~write_n;
  assign wr_pending_s = wr_en_s & (address == ADDR_PENDING);
  assign wr_mask_s    = wr_en_s & (address == ADDR_MASK);
  assign wr_edge_s    = wr_en_s & (address == ADDR_EDGE_SEL);
  assign w1c_s        = wr_pending_s ? writedata[NUM_IRQ-1:0] : {NUM_IRQ{1'b0}};
  assign unused_wdata_s = ^writedata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    de0_cv_irq_capture u_capture (
      .clk        (clk),
      .reset_n    (reset_n),
      .irq_i      (irq_in[g]),
      .edge_sel_i (edge_sel_q[g]),
      .w1c_i      (w1c_s[g]),
      .src_o      (src_s[g]),
      .pending_o  (pending_s[g])
    );
  end

  assign hit_s          = pending_s & mask_q;
  assign active_valid_s = |hit_s;

  // Priority encode: scan downward so the lowest set index is the last to win
  always_comb begin
    active_id_s = {ID_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        active_id_s = ID_W'(i);
      end else begin
        active_id_s = active_id_s;
      end
    end
  end

  // ACTIVE word layout
  always_comb begin
    active_word_s                   = {DATA_W{1'b0}};
    active_word_s[ACTIVE_VALID_BIT] = active_valid_s;
    active_word_s[ID_W-1:0]         = active_id_s;
  end

  // Read mux and next-state for the writable registers and the irq output
  always_comb begin
    readdata_d = {DATA_W{1'b0}};
    case (address)
      ADDR_PENDING:  readdata_d = DATA_W'(pending_s);
      ADDR_MASK:     readdata_d = DATA_W'(mask_q);
      ADDR_EDGE_SEL: readdata_d = DATA_W'(edge_sel_q);
      ADDR_ACTIVE:   readdata_d = active_word_s;
      ADDR_RAW:      readdata_d = DATA_W'(src_s);
      default:       readdata_d = {DATA_W{1'b0}};
    endcase
    mask_d     = wr_mask_s ? writedata[NUM_IRQ-1:0] : mask_q;
    edge_sel_d = wr_edge_s ? writedata[NUM_IRQ-1:0] : edge_sel_q;
    irq_out_d  = active_valid_s;
  end

  // Register file, read data and aggregated irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= {NUM_IRQ{1'b0}};
      edge_sel_q <= {NUM_IRQ{1'b0}};
      readdata_q <= {DATA_W{1'b0}};
      irq_out_q  <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule
